// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Two requesters share the single read port of the instruction memory.
// Port 0 is CPU fetch and port 1 is the loader/debug reader.
// The arbiter issues at most one read per cycle. A grant is decided
// combinationally in cycle N, and the response is registered and
// presented as a one-cycle pulse in cycle N+1.
module imem_port_arbiter #(
  parameter int DEPTH      = 1024,
  parameter bit FETCH_PRIO = 1'b1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // port 0: CPU fetch
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  output logic        rerr0,
  input  logic        flush0,
  // port 1: loader / debug reader
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic        rerr1,
  // instruction memory read port
  output logic        mem_ren,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  STARVE_W = 4'(STARVE_MAX);

  port_e       rr_last;
  logic [3:0]  starve_cnt;
  logic        pend_valid;
  port_e       pend_port;

  logic        req0_eff;
  logic        req1_eff;
  logic        any_grant;
  logic [31:0] sel_addr;
  logic        sel_err;

  // While in reset nothing is granted. A flush on port 0 also withholds
  // its grant, because the fetch address is being redirected.
  assign req0_eff  = req0 & ~flush0 & rst_n;
  assign req1_eff  = req1 & rst_n;
  assign any_grant = gnt0 | gnt1;

  // Arbitration: a lone requester always wins. On a conflict, fixed
  // priority favours fetch, subject to the starvation limit; otherwise
  // the two ports alternate.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_eff && req1_eff) begin
      if (FETCH_PRIO) begin
        if (starve_cnt == STARVE_W) gnt1 = 1'b1;
        else                        gnt0 = 1'b1;
      end else begin
        if (rr_last == PORT0) gnt1 = 1'b1;
        else                  gnt0 = 1'b1;
      end
    end else begin
      gnt0 = req0_eff;
      gnt1 = req1_eff;
    end
  end

  // Address check and memory drive for the granted request. An erroring
  // request never touches the memory, and an idle port reads address 0.
  always_comb begin
    sel_addr  = gnt1 ? addr1 : addr0;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= DEPTH_W);
    mem_ren   = any_grant & ~sel_err;
    mem_raddr = mem_ren ? sel_addr : 32'h0;
  end

  // Fairness state: the last granted port and the count of consecutive
  // port-1 denials. The count saturates at the starvation limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      rr_last    <= PORT1;
      starve_cnt <= 4'd0;
    end else begin
      if (gnt0)      rr_last <= PORT0;
      else if (gnt1) rr_last <= PORT1;

      if (!req1 || gnt1)              starve_cnt <= 4'd0;
      else if (starve_cnt != STARVE_W) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Response capture: the pending tag follows every grant. The data and
  // error of the granted port are latched at the edge that ends the issue
  // cycle, and they hold until that port's next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_port  <= PORT0;
      rdata0     <= 32'h0;
      rerr0      <= 1'b0;
      rdata1     <= 32'h0;
      rerr1      <= 1'b0;
    end else begin
      pend_valid <= any_grant;
      pend_port  <= gnt1 ? PORT1 : PORT0;
      if (gnt0) begin
        rdata0 <= sel_err ? 32'h0 : mem_rdata;
        rerr0  <= sel_err;
      end
      if (gnt1) begin
        rdata1 <= sel_err ? 32'h0 : mem_rdata;
        rerr1  <= sel_err;
      end
    end
  end

  // A flush arriving in the response cycle suppresses a port-0 delivery.
  // Port-1 responses are never affected by it.
  assign rvalid0 = pend_valid & (pend_port == PORT0) & ~flush0;
  assign rvalid1 = pend_valid & (pend_port == PORT1);

endmodule
